// File: rtl/sent_tx_pkg.sv
// Shared definitions for the SENT transmit frame generator.
//   sent_state_e : frame FSM states
//   SYNC_TICKS   : sync pulse length in ticks
//   NIB_BASE     : tick length of a nibble with value 0
//   CRC_SEED     : SAE J2716 CRC4 seed
//   FMT_*        : frame format codes (shared with the data register load_bit)
//   crc4_step    : one CRC4 table step, T[crc] ^ nib
package sent_tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CAPTURE,
    ST_CRC,
    ST_SYNC,
    ST_STATUS,
    ST_DATA,
    ST_CRCN,
    ST_PAUSE
  } sent_state_e;

  localparam int unsigned SYNC_TICKS = 56;
  localparam int unsigned NIB_BASE   = 12;
  localparam logic [3:0]  CRC_SEED   = 4'h5;

  localparam logic [2:0] FMT_NONE     = 3'b000;
  localparam logic [2:0] FMT_F1F2_12  = 3'b001;
  localparam logic [2:0] FMT_F1_H16   = 3'b110;
  localparam logic [2:0] FMT_F1_F2_24 = 3'b111;

  function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic [3:0] nib);
    logic [3:0] t;
    case (crc)
      4'd0:    t = 4'd0;
      4'd1:    t = 4'd13;
      4'd2:    t = 4'd7;
      4'd3:    t = 4'd10;
      4'd4:    t = 4'd14;
      4'd5:    t = 4'd3;
      4'd6:    t = 4'd9;
      4'd7:    t = 4'd4;
      4'd8:    t = 4'd1;
      4'd9:    t = 4'd12;
      4'd10:   t = 4'd6;
      4'd11:   t = 4'd11;
      4'd12:   t = 4'd15;
      4'd13:   t = 4'd2;
      4'd14:   t = 4'd8;
      default: t = 4'd5;
    endcase
    return t ^ nib;
  endfunction

endpackage

// File: rtl/sent_tx_tick_gen.sv
// SENT tick prescaler.
//   clk_tx   : transmit clock
//   reset_tx : asynchronous active-high reset
//   clear    : holds the counter at 0 and suppresses tick
//   tick     : high on the cycle the 0..TICK_DIV-1 counter wraps
module sent_tx_tick_gen #(
  parameter int unsigned TICK_DIV = 3
) (
  input  logic clk_tx,
  input  logic reset_tx,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_tx or posedge reset_tx) begin
    if (reset_tx) begin
      cnt_q <= '0;
    end else if (clear || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick = !clear && (cnt_q == LAST);

endmodule

// File: rtl/sent_tx_frame_gen.sv
// SENT frame generator: requests fast-channel data from the data register,
// packs it into nibbles, computes the J2716 CRC4 and drives the SENT line.
//   clk_tx, reset_tx   : clock, asynchronous active-high reset
//   enable_i, fmt_i    : start/continue frames while enabled with fmt != 000
//   status_i           : status nibble, sampled with the data
//   load_bit_o         : format request to the data register (000 = none)
//   done_pre_data_i    : data register strobe; data valid the following cycle
//   data_f1_i/f2_i     : fast channel data
//   sent_o             : SENT line, idles high
//   busy_o             : high outside IDLE
//   frame_done_o       : 1-cycle pulse right after the final pulse ends
module sent_tx_frame_gen
  import sent_tx_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 3,
  parameter int unsigned LOW_TICKS   = 5,
  parameter int unsigned PAUSE_TICKS = 0
) (
  input  logic        clk_tx,
  input  logic        reset_tx,
  input  logic        enable_i,
  input  logic [2:0]  fmt_i,
  input  logic [3:0]  status_i,
  output logic [2:0]  load_bit_o,
  input  logic        done_pre_data_i,
  input  logic [15:0] data_f1_i,
  input  logic [11:0] data_f2_i,
  output logic        sent_o,
  output logic        busy_o,
  output logic        frame_done_o
);

  sent_state_e state_q, state_d;
  logic [2:0]  fmt_q;
  logic [23:0] word_q;
  logic [3:0]  status_q;
  logic [3:0]  crc_q;
  logic [2:0]  nib_idx_q;
  logic [7:0]  pcnt_q;
  logic        frame_done_q;

  logic        tick;
  logic        pulse_state;
  logic        pulse_end;
  logic        frame_end;
  logic        restart;
  logic        crc_last;
  logic [2:0]  nib_cnt;
  logic [23:0] word_sh;
  logic [3:0]  cur_nib;
  logic [7:0]  pulse_len;

  // Packed word is left-aligned: the first transmitted nibble is [23:20].
  function automatic logic [23:0] pack_word(input logic [2:0] fmt, input logic [15:0] f1,
                                            input logic [11:0] f2);
    case (fmt)
      FMT_F1F2_12:  return {f1[11:0], f2[3:0], f2[7:4], f2[11:8]};
      FMT_F1_H16:   return {f1[13:0], f2[9:0]};
      FMT_F1_F2_24: return {f1, f2[7:0]};
      default:      return {f1[11:0], 12'h000};
    endcase
  endfunction

  sent_tx_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_tx   (clk_tx),
    .reset_tx (reset_tx),
    .clear    (!pulse_state),
    .tick     (tick)
  );

  assign pulse_state = (state_q == ST_SYNC) || (state_q == ST_STATUS) || (state_q == ST_DATA) ||
                       (state_q == ST_CRCN) || (state_q == ST_PAUSE);
  assign nib_cnt  = (fmt_q == FMT_F1F2_12 || fmt_q == FMT_F1_H16 || fmt_q == FMT_F1_F2_24) ? 3'd6 : 3'd3;
  assign word_sh  = word_q << {nib_idx_q, 2'b00};
  assign cur_nib  = word_sh[23:20];
  assign crc_last = (nib_idx_q == nib_cnt);
  assign restart  = enable_i && (fmt_i != FMT_NONE);

  always_comb begin
    pulse_len = '0;
    case (state_q)
      ST_SYNC:   pulse_len = 8'(SYNC_TICKS);
      ST_STATUS: pulse_len = 8'(NIB_BASE) + {4'b0000, status_q};
      ST_DATA:   pulse_len = 8'(NIB_BASE) + {4'b0000, cur_nib};
      ST_CRCN:   pulse_len = 8'(NIB_BASE) + {4'b0000, crc_q};
      ST_PAUSE:  pulse_len = 8'(PAUSE_TICKS);
      default:   pulse_len = '0;
    endcase
  end

  assign pulse_end = pulse_state && tick && (pcnt_q == pulse_len - 8'd1);
  assign frame_end = pulse_end && (((state_q == ST_CRCN) && (PAUSE_TICKS == 0)) ||
                                   (state_q == ST_PAUSE));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (restart) state_d = ST_LOAD;
      ST_LOAD:    if (done_pre_data_i) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_CRC;
      ST_CRC:     if (crc_last) state_d = ST_SYNC;
      ST_SYNC:    if (pulse_end) state_d = ST_STATUS;
      ST_STATUS:  if (pulse_end) state_d = ST_DATA;
      ST_DATA:    if (pulse_end && nib_idx_q == nib_cnt - 3'd1) state_d = ST_CRCN;
      ST_CRCN: begin
        if (pulse_end) begin
          if (PAUSE_TICKS != 0) state_d = ST_PAUSE;
          else                  state_d = restart ? ST_LOAD : ST_IDLE;
        end
      end
      ST_PAUSE:   if (pulse_end) state_d = restart ? ST_LOAD : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_tx or posedge reset_tx) begin
    if (reset_tx) begin
      state_q      <= ST_IDLE;
      fmt_q        <= FMT_NONE;
      word_q       <= '0;
      status_q     <= '0;
      crc_q        <= '0;
      nib_idx_q    <= '0;
      pcnt_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= frame_end;
      if (state_d == ST_LOAD && state_q != ST_LOAD) fmt_q <= fmt_i;
      if (!pulse_state || pulse_end) pcnt_q <= '0;
      else if (tick)                 pcnt_q <= pcnt_q + 8'd1;
      case (state_q)
        // Data register outputs are valid the cycle after done, i.e. here.
        ST_CAPTURE: begin
          word_q    <= pack_word(fmt_q, data_f1_i, data_f2_i);
          status_q  <= status_i;
          crc_q     <= CRC_SEED;
          nib_idx_q <= '0;
        end
        // One nibble per cycle, then the zero-nibble augmentation step.
        ST_CRC: begin
          if (crc_last) begin
            crc_q     <= crc4_step(crc_q, 4'h0);
            nib_idx_q <= '0;
          end else begin
            crc_q     <= crc4_step(crc_q, cur_nib);
            nib_idx_q <= nib_idx_q + 3'd1;
          end
        end
        ST_DATA: if (pulse_end) nib_idx_q <= nib_idx_q + 3'd1;
        default: ;
      endcase
    end
  end

  assign load_bit_o   = (state_q == ST_LOAD) ? fmt_q : FMT_NONE;
  assign busy_o       = (state_q != ST_IDLE);
  assign frame_done_o = frame_done_q;
  assign sent_o       = !(pulse_state && (pcnt_q < 8'(LOW_TICKS)));

endmodule

// File: doc/sent_tx_frame_gen.md
Name: sent_tx_frame_gen

Overview:
Downstream consumer of sent_tx_data_reg on the SENT transmit path. It selects the frame format, requests fast-channel data from the data register over the load_bit/done_pre_data handshake, and packs that data into nibbles. It then computes the SAE J2716 CRC4 and drives the serial SENT line: sync pulse, status nibble, data nibbles, CRC nibble and an optional pause pulse, all timed in ticks.

Parameters:
TICK_DIV, 3, clk_tx cycles per SENT tick (≥1)
LOW_TICKS, 5, low-phase length of every pulse, in ticks
PAUSE_TICKS, 0, length of the pause pulse in ticks; 0 = no pause pulse (must be 0 or ≥12)

Ports:
clk_tx  in  1  transmit clock
reset_tx  in  1  asynchronous, active-high reset
enable_i  in  1  while high, frames are sent back to back
fmt_i  in  3  frame format, same encoding as load_bit; 000 = none
status_i  in  4  status/communication nibble
load_bit_o  out  3  format request to the data register; 000 = no request
done_pre_data_i  in  1  1-cycle strobe from the data register
data_f1_i  in  16  fast channel 1 from the data register
data_f2_i  in  12  fast channel 2 from the data register
sent_o  out  1  SENT line; idles high
busy_o  out  1  high from LOAD entry until frame end
frame_done_o  out  1  1-cycle pulse when the last pulse of a frame completes

Behaviour:
- Reset values: sent_o=1, load_bit_o=000, busy_o=0, frame_done_o=0, FSM=IDLE, tick counter=0, CRC=0.
- Reset asserted mid-frame aborts the frame at once and forces the reset values. No partial-frame recovery.
- Tick generator: a free-running counter from 0 to TICK_DIV-1; tick=1 on the cycle it wraps. It is cleared in IDLE. All pulse lengths count ticks.
- FSM: IDLE → LOAD → CAPTURE → CRC → SYNC → STATUS → DATA → CRCN → [PAUSE] → (LOAD if enable_i && fmt_i≠000, else IDLE).
- IDLE: leave when enable_i=1 and fmt_i≠000. Register fmt at this point; fmt is also re-registered at each LOAD entry. fmt_i changes mid-frame are ignored.
- LOAD: load_bit_o=registered fmt. When done_pre_data_i=1 in cycle N, set load_bit_o=000 from cycle N+1 and go to CAPTURE.
- CAPTURE: sample data_f1_i, data_f2_i and status_i in cycle N+1 (the data register updates its outputs one cycle after done).
- Nibble packing (first transmitted first):
  - 001: f1[11:8], f1[7:4], f1[3:0], f2[3:0], f2[7:4], f2[11:8] (F2 nibble order reversed). 6 nibbles.
  - 010–101: f1[11:8], f1[7:4], f1[3:0]. 3 nibbles.
  - 110: 24-bit word {f1[13:0], f2[9:0]}, MSB nibble first. 6 nibbles.
  - 111: 24-bit word {f1[15:0], f2[7:0]}, MSB nibble first. 6 nibbles.
- CRC: one nibble per clock. Start with crc=4'h5; for each data nibble d, crc=T[crc]^d. Then one augmentation step, crc=T[crc].
  - T = {0,13,7,10,14,3,9,4,1,12,6,11,15,2,8,5}.
  - The status nibble is excluded from the CRC.
  - Latency is (nibbles+1) cycles, then SYNC begins.
- Pulse shape: each pulse starts on a tick boundary with sent_o=0 for LOW_TICKS ticks, then sent_o=1 for the rest of the pulse.
  - SYNC pulse = 56 ticks.
  - Nibble value v = 12+v ticks.
  - PAUSE pulse = PAUSE_TICKS ticks.
- Pulses are contiguous, with no idle gap inside a frame. On back-to-back frames, sent_o stays high through LOAD/CAPTURE/CRC; that gap is accepted.
- frame_done_o pulses in the cycle the final pulse's last tick ends. busy_o drops in the same cycle if the FSM returns to IDLE.
- enable_i falling mid-frame: the current frame completes, then the FSM goes to IDLE.
- fmt_i=000 at a frame boundary: go to IDLE.
- If done_pre_data_i never arrives, stay in LOAD with the request held. There is no timeout.

Decomposition:
- Package sent_tx_pkg holds:
  - the state enum;
  - constants SYNC_TICKS=56, NIB_BASE=12, CRC_SEED=4'h5;
  - the format codes;
  - the CRC4 table as a constant function crc4_step(crc, nib).
- One sub-module, sent_tx_tick_gen: TICK_DIV prescaler with clear input and tick output.

Test Plan:
- fmt=001, status=0, f1=0, f2=0, TICK_DIV=3:
  - Expect load_bit_o=001 until done, then 000 the next cycle.
  - Expect a 56-tick sync pulse, seven 12-tick nibbles, and CRC nibble 5 (17 ticks).
  - Frame = 157 ticks = 471 clk_tx cycles after SYNC start.
- fmt=010, f1=0: 3 data nibbles, CRC=9 (21 ticks), frame = 125 ticks.
- fmt=001, f1=12'hABC, f2=12'h123: data nibble sequence A,B,C,3,2,1. Measure each nibble as 12+v ticks; the low phase is exactly 5 ticks.
- fmt=111, f1=16'hFEDC, f2=8'hBA: nibbles F,E,D,C,B,A. The F nibble is 27 ticks. CRC matches the reference model.
- enable_i held high, PAUSE_TICKS=20: two consecutive frames, each with a 20-tick pause and a frame_done_o pulse.
  - Drop enable mid-frame 2: frame 2 completes, then IDLE.
- Assert reset_tx during DATA: sent_o=1 immediately, load_bit_o=000, busy_o=0.
  - After release with enable=1, a new frame starts with a fresh LOAD.
